// File: rtl/activation_pkg.sv
// rtl/activation_pkg.sv - shared mode encoding and count-width helper for the activation unit
package activation_pkg;

   typedef enum logic [1:0] {
      LINEAR = 2'd0,
      RELU   = 2'd1,
      LEAKY  = 2'd2,
      CLAMP  = 2'd3
   } mode_t;

   // Width of the per-frame negative-lane counter for n lanes per beat
   function automatic int count_width(input int n);
      return $clog2(n * 65536);
   endfunction

endpackage

// File: rtl/activation_lane.sv
// rtl/activation_lane.sv - combinational activation of one signed lane
module activation_lane
   import activation_pkg::*;
#(
   parameter int W          = 32,
   parameter int LEAK_SHIFT = 3
) (
   input  logic signed [W-1:0] x,
   input  mode_t               mode,
   input  logic signed [W-1:0] cap,
   output logic signed [W-1:0] y,
   output logic                is_neg
);

   logic signed [W-1:0] cap_eff;

   assign is_neg  = x[W-1];
   // A negative cap would invert the clamp range, so it collapses to zero
   assign cap_eff = cap[W-1] ? '0 : cap;

   // Select the activation function for this lane
   always_comb begin
      y = x;
      case (mode)
         RELU:    if (is_neg) y = '0;
         LEAKY:   if (is_neg) y = x >>> LEAK_SHIFT;
         CLAMP: begin
            if (is_neg)            y = '0;
            else if (x > cap_eff)  y = cap_eff;
         end
         default: y = x;
      endcase
   end

endmodule

// File: rtl/activation_unit.sv
// rtl/activation_unit.sv - two-stage streaming activation with per-frame negative-lane count
module activation_unit
   import activation_pkg::*;
#(
   parameter int W          = 32,
   parameter int N          = 4,
   parameter int LEAK_SHIFT = 3
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [1:0]                  mode,
   input  logic [W-1:0]                cap,
   input  logic                        s_valid,
   output logic                        s_ready,
   input  logic [N*W-1:0]              s_data,
   input  logic                        s_last,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic [N*W-1:0]              m_data,
   output logic                        m_last,
   output logic [count_width(N)-1:0]   m_neg_count
);

   localparam int CW = count_width(N);
   localparam int BW = $clog2(N + 1);

   logic [N*W-1:0] lane_y;
   logic [N-1:0]   lane_neg;
   logic [BW-1:0]  beat_neg;

   logic           en;
   logic           s1_valid;
   logic [N*W-1:0] s1_data;
   logic           s1_last;
   logic [BW-1:0]  s1_neg;

   logic [CW-1:0]  frame_cnt;
   logic [CW:0]    frame_sum;
   logic [CW-1:0]  frame_next;

   // mode/cap feed the lanes directly so they are captured with the beat on its transfer edge
   for (genvar i = 0; i < N; i++) begin : g_lane
      activation_lane #(
         .W          (W),
         .LEAK_SHIFT (LEAK_SHIFT)
      ) u_lane (
         .x      (s_data[i*W +: W]),
         .mode   (mode_t'(mode)),
         .cap    (cap),
         .y      (lane_y[i*W +: W]),
         .is_neg (lane_neg[i])
      );
   end

   // Count negative lanes in the incoming beat
   always_comb begin
      beat_neg = '0;
      for (int i = 0; i < N; i++) begin
         beat_neg = beat_neg + {{(BW-1){1'b0}}, lane_neg[i]};
      end
   end

   // Whole pipeline advances together whenever the output register can drain
   assign en      = !m_valid || m_ready;
   assign s_ready = en;

   // Saturating frame accumulation of the beat leaving S1
   assign frame_sum  = {1'b0, frame_cnt} + {{(CW+1-BW){1'b0}}, s1_neg};
   assign frame_next = frame_sum[CW] ? {CW{1'b1}} : frame_sum[CW-1:0];

   // S1: register activated lanes, last flag and per-beat negative count
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_last  <= 1'b0;
         s1_neg   <= '0;
      end else if (en) begin
         s1_valid <= s_valid;
         if (s_valid) begin
            s1_data <= lane_y;
            s1_last <= s_last;
            s1_neg  <= beat_neg;
         end
      end
   end

   // S2: output register plus frame counter, total published only with the last beat
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m_valid     <= 1'b0;
         m_data      <= '0;
         m_last      <= 1'b0;
         m_neg_count <= '0;
         frame_cnt   <= '0;
      end else if (en) begin
         m_valid <= s1_valid;
         m_last  <= s1_valid && s1_last;
         if (s1_valid) begin
            m_data <= s1_data;
            if (s1_last) begin
               m_neg_count <= frame_next;
               frame_cnt   <= '0;
            end else begin
               m_neg_count <= '0;
               frame_cnt   <= frame_next;
            end
         end else begin
            m_neg_count <= '0;
         end
      end
   end

endmodule
